// File: rtl/comp_serial_ctrl.sv
// comp_serial_ctrl
//
// Serial magnitude-compare controller. Compares two WIDTH-bit unsigned
// operands one bit per clock, MSB first, with a 1-bit comparator cell.
// The compare stops at the first differing bit. The result is registered
// and held until the next accepted start. done is a one-cycle strobe.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  compare request, sampled only in IDLE
//   a_in   operand A, captured on the accepting edge
//   b_in   operand B, captured on the accepting edge
//   busy   high in RUN and DONE
//   done   one-cycle strobe, result valid
//   gt     A > B (held)
//   lt     A < B (held)
//   eq     A == B (held)

module comp_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    // Counter holds the index of the bit under compare; it needs at least one bit.
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [CntW-1:0]   cnt_q;

    // 1-bit comparator cell on the current MSBs.
    logic a_msb;
    logic b_msb;
    logic cell_gt;
    logic cell_lt;
    logic cell_eq;

    always_comb begin
        a_msb   = a_q[WIDTH-1];
        b_msb   = b_q[WIDTH-1];
        cell_gt = a_msb & ~b_msb;
        cell_lt = ~a_msb & b_msb;
        cell_eq = ~(a_msb ^ b_msb);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        cnt_q   <= CntW'(WIDTH - 1);
                        // Flags read 0 from acceptance until the result edge.
                        gt      <= 1'b0;
                        lt      <= 1'b0;
                        eq      <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (!cell_eq) begin
                        gt      <= cell_gt;
                        lt      <= cell_lt;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else if (cnt_q == '0) begin
                        eq      <= 1'b1;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        a_q   <= a_q << 1;
                        b_q   <= b_q << 1;
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp_serial_ctrl.sv
// Testbench for comp_serial_ctrl (WIDTH=8). Stimulus pushes the expected
// result and its done cycle into a queue; a monitor pops on every done.

module tb_comp_serial_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             gt;
    logic             lt;
    logic             eq;

    comp_serial_ctrl #(
        .WIDTH(WIDTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a_in (a_in),
        .b_in (b_in),
        .busy (busy),
        .done (done),
        .gt   (gt),
        .lt   (lt),
        .eq   (eq)
    );

    typedef struct packed {
        logic        gt;
        logic        lt;
        logic        eq;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          total;
    int          bad;
    logic        prev_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            check("done_single_cycle", 32'(prev_done), 0);
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("res_gt", 32'(gt), 32'(e.gt));
                check("res_lt", 32'(lt), 32'(e.lt));
                check("res_eq", 32'(eq), 32'(e.eq));
                check("done_cycle", cyc, e.cyc);
            end
            check("onehot_flags", 32'(gt) + 32'(lt) + 32'(eq), 1);
        end
        prev_done = done;
    end

    // Issues start for one cycle; returns at the negedge after the accepting edge E0.
    // m is the number of RUN edges until the result edge.
    task automatic do_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic egt, input logic elt, input logic eeq,
                            input int unsigned m);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        e.gt  = egt;
        e.lt  = elt;
        e.eq  = eeq;
        e.cyc = cyc + 1 + m;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) check("idle_timeout", 1, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b1;
        a_in  = WIDTH'($urandom);
        b_in  = WIDTH'($urandom);

        // Reset with start asserted and random operands.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
            check("rst_flags", {29'd0, gt, lt, eq}, 0);
            a_in = WIDTH'($urandom);
            b_in = WIDTH'($urandom);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_after_rst_busy", 32'(busy), 0);

        // MSB differs: result at E1.
        do_start(8'hA5, 8'h25, 1'b1, 1'b0, 1'b0, 1);
        check("t1_busy_e0", 32'(busy), 1);
        check("t1_flags_e0", {29'd0, gt, lt, eq}, 0);
        @(negedge clk);
        check("t1_busy_e1", 32'(busy), 1);
        check("t1_done_e1", 32'(done), 1);
        @(negedge clk);
        check("t1_busy_e2", 32'(busy), 0);
        check("t1_done_e2", 32'(done), 0);
        check("t1_gt_held", 32'(gt), 1);

        // LSB differs: full-length compare, flags 0 while running.
        wait_idle();
        do_start(8'h3C, 8'h3D, 1'b0, 1'b1, 1'b0, 8);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check("t2_flags_run", {29'd0, gt, lt, eq}, 0);
            check("t2_done_run", 32'(done), 0);
        end
        wait_idle();

        // Equal operands, then a new compare clears eq at acceptance.
        do_start(8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 8);
        wait_idle();
        check("t3_eq_held", 32'(eq), 1);
        do_start(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1);
        check("t3_eq_cleared", 32'(eq), 0);
        wait_idle();

        // start and operand changes during RUN are ignored.
        do_start(8'h10, 8'h11, 1'b0, 1'b1, 1'b0, 8);
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        a_in  = 8'h77;
        wait_idle();
        @(negedge clk);
        check("t4_no_extra", sb.size(), 0);

        // Reset at E3 of an equal compare aborts it without done.
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'h5A;
        b_in  = 8'h5A;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", 32'(busy), 0);
        check("t5_done", 32'(done), 0);
        check("t5_flags", {29'd0, gt, lt, eq}, 0);
        @(negedge clk);
        check("t5_still_idle", 32'(busy), 0);
        do_start(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1);
        wait_idle();
        @(negedge clk);

        if (sb.size() != 0) check("missing_done", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
